// File: rtl/qformat_requantize.sv
// Streaming requantizer: signed Q(2I).(2F) product -> signed Q(I).(F) value.
// Two-stage valid/ready pipeline (round/shift, then saturate) with a sticky saturation counter.
module qformat_requantize #(
   parameter int unsigned NUM_FIXED_BITS      = 8,
   parameter int unsigned NUM_FRACTIONAL_BITS = 8,
   parameter int unsigned ROUND               = 1,
   parameter int unsigned SAT_COUNT_BITS      = 16
) (
   input  logic                                                         clock,
   input  logic                                                         reset,
   input  logic                                                         in_valid,
   output logic                                                         in_ready,
   input  logic [2*(NUM_FIXED_BITS+NUM_FRACTIONAL_BITS)-1:0]            in_product,
   output logic                                                         out_valid,
   input  logic                                                         out_ready,
   output logic [NUM_FIXED_BITS+NUM_FRACTIONAL_BITS-1:0]                out_value,
   output logic                                                         out_saturated,
   input  logic                                                         clear_count,
   output logic [SAT_COUNT_BITS-1:0]                                    sat_count
);

   localparam int unsigned T  = NUM_FIXED_BITS + NUM_FRACTIONAL_BITS;
   localparam int unsigned F  = NUM_FRACTIONAL_BITS;
   localparam int unsigned PW = 2 * T;
   localparam int unsigned SW = PW + 1;
   localparam int unsigned QW = SW - F;

   localparam logic signed [QW-1:0] MAX_Q   = {{(QW-T+1){1'b0}}, {(T-1){1'b1}}};
   localparam logic signed [QW-1:0] MIN_Q   = {{(QW-T+1){1'b1}}, {(T-1){1'b0}}};
   localparam logic        [SW-1:0] RND_ADD = (ROUND != 0) ? (SW'(1) << (F - 1)) : '0;

   logic                 s1_valid;
   logic signed [QW-1:0] s1_q;
   logic                 s1_adv;
   logic                 s2_adv;
   logic        [SW-1:0] sum;
   logic signed [QW-1:0] s1_next;
   logic                 unused_frac;
   logic        [T-1:0]  sat_value;
   logic                 sat_flag;

   // Handshake: a stage advances when it is empty or its consumer advances.
   assign s2_adv   = !out_valid || out_ready;
   assign s1_adv   = !s1_valid || s2_adv;
   assign in_ready = s1_adv;

   // Sign-extend, add the half-LSB, then keep the upper bits (arithmetic shift by F).
   assign sum         = {in_product[PW-1], in_product} + RND_ADD;
   assign s1_next     = $signed(sum[SW-1:F]);
   assign unused_frac = ^sum[F-1:0];

   always_comb begin
      sat_flag  = 1'b0;
      sat_value = s1_q[T-1:0];
      if (s1_q > MAX_Q) begin
         sat_flag  = 1'b1;
         sat_value = MAX_Q[T-1:0];
      end else if (s1_q < MIN_Q) begin
         sat_flag  = 1'b1;
         sat_value = MIN_Q[T-1:0];
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         s1_valid <= 1'b0;
         s1_q     <= '0;
      end else if (s1_adv) begin
         s1_valid <= in_valid;
         if (in_valid) s1_q <= s1_next;
      end
   end

   // Output register only loads real data so a held or drained value stays put.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         out_valid     <= 1'b0;
         out_value     <= '0;
         out_saturated <= 1'b0;
      end else if (s2_adv) begin
         out_valid <= s1_valid;
         if (s1_valid) begin
            out_value     <= sat_value;
            out_saturated <= sat_flag;
         end
      end
   end

   // Clear wins over a same-cycle increment; counter sticks at all-ones.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sat_count <= '0;
      end else if (clear_count) begin
         sat_count <= '0;
      end else if (out_valid && out_ready && out_saturated && !(&sat_count)) begin
         sat_count <= sat_count + SAT_COUNT_BITS'(1);
      end
   end

endmodule

// File: tb/tb_qformat_requantize.sv
// Bench for qformat_requantize: vector table, backpressure/counter/reset sequences,
// and randomized traffic scored against an arithmetic reference model.
module tb_qformat_requantize;

   logic        clock;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_product;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_value;
   logic        out_saturated;
   logic        clear_count;
   logic [15:0] sat_count;

   logic        t_in_ready, t_out_valid, t_out_saturated;
   logic [15:0] t_out_value, t_sat_count;
   logic        c_in_ready, c_out_valid, c_out_saturated;
   logic [15:0] c_out_value;
   logic [1:0]  c_sat_count;

   int passed = 0;
   int total  = 0;

   qformat_requantize dut (
      .clock(clock), .reset(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_product(in_product),
      .out_valid(out_valid), .out_ready(out_ready), .out_value(out_value),
      .out_saturated(out_saturated), .clear_count(clear_count), .sat_count(sat_count));

   qformat_requantize #(.ROUND(0)) dut_t (
      .clock(clock), .reset(rst_n),
      .in_valid(in_valid), .in_ready(t_in_ready), .in_product(in_product),
      .out_valid(t_out_valid), .out_ready(out_ready), .out_value(t_out_value),
      .out_saturated(t_out_saturated), .clear_count(clear_count), .sat_count(t_sat_count));

   qformat_requantize #(.SAT_COUNT_BITS(2)) dut_c (
      .clock(clock), .reset(rst_n),
      .in_valid(in_valid), .in_ready(c_in_ready), .in_product(in_product),
      .out_valid(c_out_valid), .out_ready(out_ready), .out_value(c_out_value),
      .out_saturated(c_out_saturated), .clear_count(clear_count), .sat_count(c_sat_count));

   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   // Reference: real-valued product scaled by 2^8, optional +0.5 LSB, floor, clamp to int16.
   function automatic logic [16:0] model(input logic [31:0] p, input bit rnd);
      longint v;
      v = longint'($signed(p));
      if (rnd) v = v + 128;
      v = v >>> 8;
      if (v > 32767)  return {1'b1, 16'h7FFF};
      if (v < -32768) return {1'b1, 16'h8000};
      return {1'b0, 16'(v)};
   endfunction

   // Scoreboard on the default instance.
   logic [16:0] exp_q[$];
   logic [15:0] mdl_cnt;
   bit          stall_pend;
   logic [16:0] held;

   always @(posedge clock) begin
      logic [16:0] e;
      if (!rst_n) begin
         exp_q.delete();
         mdl_cnt    = '0;
         stall_pend = 1'b0;
      end else begin
         if (stall_pend) begin
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_hold", 32'({out_saturated, out_value}), 32'(held));
         end
         stall_pend = out_valid && !out_ready;
         held       = {out_saturated, out_value};
         if (in_valid && in_ready) exp_q.push_back(model(in_product, 1'b1));
         e = '0;
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               total++;
               $display("FAIL sb_extra: got unexpected output 0x%0h, expected none", out_value);
            end else begin
               e = exp_q.pop_front();
               chk("sb_out", 32'({out_saturated, out_value}), 32'(e));
            end
         end
         if (clear_count) mdl_cnt = '0;
         else if (e[16] && mdl_cnt != 16'hFFFF) mdl_cnt = mdl_cnt + 16'd1;
      end
   end

   typedef struct {
      logic [31:0] prod;
      logic [15:0] rv;
      logic        rs;
      logic [15:0] tv;
      logic        ts;
   } vec_t;

   vec_t vecs[11];

   initial begin
      vecs[0]  = '{32'h0003_0000, 16'h0300, 1'b0, 16'h0300, 1'b0};
      vecs[1]  = '{32'h0000_0080, 16'h0001, 1'b0, 16'h0000, 1'b0};
      vecs[2]  = '{32'hFFFF_FF80, 16'h0000, 1'b0, 16'hFFFF, 1'b0};
      vecs[3]  = '{32'h007F_FF7F, 16'h7FFF, 1'b0, 16'h7FFF, 1'b0};
      vecs[4]  = '{32'h007F_FF80, 16'h7FFF, 1'b1, 16'h7FFF, 1'b0};
      vecs[5]  = '{32'hFF7F_0000, 16'h8000, 1'b1, 16'h8000, 1'b1};
      vecs[6]  = '{32'hFF80_0000, 16'h8000, 1'b0, 16'h8000, 1'b0};
      vecs[7]  = '{32'hFF7F_FF80, 16'h8000, 1'b0, 16'h8000, 1'b1};
      vecs[8]  = '{32'h8000_0000, 16'h8000, 1'b1, 16'h8000, 1'b1};
      vecs[9]  = '{32'h7FFF_FFFF, 16'h7FFF, 1'b1, 16'h7FFF, 1'b1};
      vecs[10] = '{32'hFFFF_FE80, 16'hFFFF, 1'b0, 16'hFFFE, 1'b0};

      clock = 1'b0; rst_n = 1'b0;
      in_valid = 1'b0; in_product = '0; out_ready = 1'b0; clear_count = 1'b0;
      repeat (3) @(negedge clock);
      rst_n = 1'b1;
      #1;
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_value", 32'(out_value), 32'd0);
      chk("rst_out_sat", 32'(out_saturated), 32'd0);
      chk("rst_sat_count", 32'(sat_count), 32'd0);

      // Vector table: one item at a time, output expected two cycles after transfer.
      out_ready = 1'b1;
      for (int i = 0; i < 11; i++) begin
         @(negedge clock);
         in_valid = 1'b1; in_product = vecs[i].prod;
         @(negedge clock);
         in_valid = 1'b0;
         chk($sformatf("vec%0d_early", i), 32'(out_valid), 32'd0);
         @(negedge clock);
         chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'd1);
         chk($sformatf("vec%0d_rval", i), 32'(out_value), 32'(vecs[i].rv));
         chk($sformatf("vec%0d_rsat", i), 32'(out_saturated), 32'(vecs[i].rs));
         chk($sformatf("vec%0d_tval", i), 32'(t_out_value), 32'(vecs[i].tv));
         chk($sformatf("vec%0d_tsat", i), 32'(t_out_saturated), 32'(vecs[i].ts));
         if (i == 5) begin
            @(negedge clock);
            chk("bound_sat_count", 32'(sat_count), 32'd2);
         end
      end
      @(negedge clock);
      chk("table_sat_count", 32'(sat_count), 32'(mdl_cnt));

      // Backpressure: A, B, C with the sink stalled, then released.
      out_ready = 1'b0;
      @(negedge clock);
      in_valid = 1'b1; in_product = 32'h0001_0000;
      #1 chk("bp_ready_a", 32'(in_ready), 32'd1);
      @(negedge clock);
      in_product = 32'h0002_0000;
      #1 chk("bp_ready_b", 32'(in_ready), 32'd1);
      @(negedge clock);
      in_product = 32'h0003_0000;
      #1 chk("bp_ready_c", 32'(in_ready), 32'd0);
      chk("bp_hold_a", 32'(out_value), 32'h0100);
      repeat (2) begin
         @(negedge clock);
         chk("bp_still_a", 32'(out_value), 32'h0100);
         chk("bp_still_blocked", 32'(in_ready), 32'd0);
      end
      @(negedge clock);
      out_ready = 1'b1;
      #1 chk("bp_release_ready", 32'(in_ready), 32'd1);
      @(negedge clock);
      in_valid = 1'b0;
      chk("bp_out_b", 32'({out_valid, out_value}), 32'h1_0200);
      @(negedge clock);
      chk("bp_out_c", 32'({out_valid, out_value}), 32'h1_0300);
      @(negedge clock);
      chk("bp_drained", 32'(out_valid), 32'd0);

      // Counter: stick at all-ones, and clear beats a same-cycle saturated transfer.
      clear_count = 1'b1;
      @(negedge clock);
      clear_count = 1'b0;
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1; in_product = 32'h7FFF_FFFF;
         @(negedge clock);
      end
      in_valid = 1'b0;
      repeat (3) @(negedge clock);
      chk("cnt_stuck", 32'(c_sat_count), 32'd3);
      chk("cnt_five", 32'(sat_count), 32'd5);
      in_valid = 1'b1; in_product = 32'h8000_0000;
      @(negedge clock);
      in_valid = 1'b0;
      @(negedge clock);
      chk("cnt_clr_xfer_valid", 32'({out_valid, out_saturated}), 32'd3);
      clear_count = 1'b1;
      @(negedge clock);
      clear_count = 1'b0;
      chk("cnt_clr_small", 32'(c_sat_count), 32'd0);
      chk("cnt_clr_wide", 32'(sat_count), 32'd0);

      // Asynchronous reset with two items in flight.
      out_ready = 1'b0;
      @(negedge clock);
      in_valid = 1'b1; in_product = 32'h0004_0000;
      @(negedge clock);
      in_product = 32'h0005_0000;
      @(negedge clock);
      in_valid = 1'b0;
      chk("rst2_pre_valid", 32'(out_valid), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("rst2_valid_now", 32'(out_valid), 32'd0);
      chk("rst2_value_now", 32'(out_value), 32'd0);
      @(negedge clock);
      rst_n = 1'b1;
      out_ready = 1'b1;
      #1 chk("rst2_in_ready", 32'(in_ready), 32'd1);
      repeat (4) begin
         @(negedge clock);
         chk("rst2_no_stale", 32'(out_valid), 32'd0);
      end

      // Randomized traffic against the scoreboard.
      for (int i = 0; i < 400; i++) begin
         @(negedge clock);
         in_valid    = ($urandom_range(0, 3) != 0);
         out_ready   = ($urandom_range(0, 3) != 0);
         clear_count = ($urandom_range(0, 31) == 0);
         case ($urandom_range(0, 2))
            0:       in_product = $urandom;
            1:       in_product = {{8{1'($urandom)}}, 24'($urandom)};
            default: in_product = {{16{1'($urandom)}}, 16'($urandom)};
         endcase
      end
      @(negedge clock);
      in_valid = 1'b0; out_ready = 1'b1; clear_count = 1'b0;
      repeat (5) @(negedge clock);
      chk("rand_drained", 32'(exp_q.size()), 32'd0);
      chk("rand_sat_count", 32'(sat_count), 32'(mdl_cnt));

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
